// File: rtl/iomem_timer.sv
// Memory-mapped prescaled 32-bit down-counter with auto-reload, sticky expiry flag, tick and irq.
// Optional capture register and capture_in port are enabled by defining IOMEM_TIMER_CAPTURE_EN.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    input  logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_rdata,
    output logic        tick,
    output logic        irq
`ifdef IOMEM_TIMER_CAPTURE_EN
    ,
    input  logic        capture_in
`endif
);

    typedef enum logic [7:0] {
        REG_CTRL     = 8'h00,
        REG_PRESCALE = 8'h04,
        REG_COUNT    = 8'h08,
        REG_RELOAD   = 8'h0C,
        REG_STATUS   = 8'h10,
        REG_CAPTURE  = 8'h14
    } reg_off_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] wd,
                                                input logic [3:0]  ws);
        logic [31:0] r;
        r = old_v;
        for (int unsigned b = 0; b < 4; b++) begin
            if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    logic                  en_q, en_d;
    logic                  ar_q, ar_d;
    logic                  ie_q, ie_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pc_q, pc_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           reload_q, reload_d;
    logic                  exp_q, exp_d;
    logic                  tick_q, tick_d;
    logic                  ready_q;
    logic [31:0]           rdata_q, rdata_d;
    logic                  cap_bit;

    reg_off_e    off;
    logic        hit;
    logic        wr;
    logic        count_wr;
    logic        dec_evt;
    logic        expire;
    logic [31:0] prescale_ext;

`ifdef IOMEM_TIMER_CAPTURE_EN
    logic        cap_q, cap_d;
    logic [31:0] capture_q, capture_d;
    logic        cap_in_prev_q;
    logic        cap_evt;

    assign cap_evt = capture_in && !cap_in_prev_q;
    assign cap_bit = cap_q;
`else
    assign cap_bit = 1'b0;
`endif

    assign off          = reg_off_e'(iomem_addr[7:0]);
    assign hit          = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]) && !ready_q;
    assign wr           = hit && (iomem_wstrb != 4'b0000);
    assign count_wr     = wr && (off == REG_COUNT);
    assign dec_evt      = en_q && (pc_q == prescale_q);
    // A bus write to COUNT on the decrement edge overrides the expiry entirely.
    assign expire       = dec_evt && (count_q == '0) && !count_wr;
    assign prescale_ext = 32'(prescale_q);

    always_comb begin
        en_d       = en_q;
        ar_d       = ar_q;
        ie_d       = ie_q;
        prescale_d = prescale_q;
        pc_d       = pc_q;
        count_d    = count_q;
        reload_d   = reload_q;
        exp_d      = exp_q;
        tick_d     = 1'b0;
`ifdef IOMEM_TIMER_CAPTURE_EN
        cap_d      = cap_q;
        capture_d  = capture_q;
        if (cap_evt) begin
            capture_d = count_q;
            cap_d     = 1'b1;
        end
`endif

        if (en_q) begin
            pc_d = dec_evt ? '0 : pc_q + PRESCALE_W'(1);
        end
        if (dec_evt) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else if (ar_q) begin
                count_d = reload_q;
            end
        end
        if (expire) begin
            exp_d  = 1'b1;
            tick_d = 1'b1;
            if (!ar_q) en_d = 1'b0;
        end

        // Bus writes are applied last so they win over counter-side updates.
        if (wr) begin
            case (off)
                REG_CTRL: begin
                    if (iomem_wstrb[0]) begin
                        en_d = iomem_wdata[0];
                        ar_d = iomem_wdata[1];
                        ie_d = iomem_wdata[2];
                        if (iomem_wdata[0] && !en_q) pc_d = '0;
                    end
                end
                REG_PRESCALE: prescale_d = PRESCALE_W'(merge_bytes(prescale_ext, iomem_wdata, iomem_wstrb));
                REG_COUNT:    count_d    = merge_bytes(count_q, iomem_wdata, iomem_wstrb);
                REG_RELOAD:   reload_d   = merge_bytes(reload_q, iomem_wdata, iomem_wstrb);
                REG_STATUS: begin
                    if (iomem_wstrb[0] && iomem_wdata[0] && !expire) exp_d = 1'b0;
`ifdef IOMEM_TIMER_CAPTURE_EN
                    if (iomem_wstrb[0] && iomem_wdata[1] && !cap_evt) cap_d = 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (off)
                REG_CTRL:     rdata_d = {29'b0, ie_q, ar_q, en_q};
                REG_PRESCALE: rdata_d = prescale_ext;
                REG_COUNT:    rdata_d = count_q;
                REG_RELOAD:   rdata_d = reload_q;
                REG_STATUS:   rdata_d = {30'b0, cap_bit, exp_q};
`ifdef IOMEM_TIMER_CAPTURE_EN
                REG_CAPTURE:  rdata_d = capture_q;
`endif
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q          <= 1'b0;
            ar_q          <= 1'b0;
            ie_q          <= 1'b0;
            prescale_q    <= '0;
            pc_q          <= '0;
            count_q       <= '0;
            reload_q      <= '0;
            exp_q         <= 1'b0;
            tick_q        <= 1'b0;
            ready_q       <= 1'b0;
            rdata_q       <= '0;
`ifdef IOMEM_TIMER_CAPTURE_EN
            cap_q         <= 1'b0;
            capture_q     <= '0;
            cap_in_prev_q <= 1'b0;
`endif
        end else begin
            en_q          <= en_d;
            ar_q          <= ar_d;
            ie_q          <= ie_d;
            prescale_q    <= prescale_d;
            pc_q          <= pc_d;
            count_q       <= count_d;
            reload_q      <= reload_d;
            exp_q         <= exp_d;
            tick_q        <= tick_d;
            ready_q       <= hit;
            rdata_q       <= rdata_d;
`ifdef IOMEM_TIMER_CAPTURE_EN
            cap_q         <= cap_d;
            capture_q     <= capture_d;
            cap_in_prev_q <= capture_in;
`endif
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign tick        = tick_q;
    assign irq         = exp_q & ie_q;

endmodule

// File: tb/tb_iomem_timer.sv
// Directed self-checking bench for iomem_timer: bus handshake, byte strobes, auto-reload,
// one-shot, write/expiry collisions, W1C vs set, reset mid-transfer and optional capture.
module tb_iomem_timer;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam logic [31:0] A_CTRL     = BASE + 32'h00;
    localparam logic [31:0] A_PRESCALE = BASE + 32'h04;
    localparam logic [31:0] A_COUNT    = BASE + 32'h08;
    localparam logic [31:0] A_RELOAD   = BASE + 32'h0C;
    localparam logic [31:0] A_STATUS   = BASE + 32'h10;
    localparam logic [31:0] A_CAPTURE  = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_rdata;
    logic        tick;
    logic        irq;
`ifdef IOMEM_TIMER_CAPTURE_EN
    logic        capture_in = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int tick_cnt = 0;

    iomem_timer #(
        .BASE_ADDR (BASE),
        .PRESCALE_W(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_wstrb(iomem_wstrb),
        .iomem_rdata(iomem_rdata),
        .tick       (tick),
        .irq        (irq)
`ifdef IOMEM_TIMER_CAPTURE_EN
        ,
        .capture_in (capture_in)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick === 1'b1) tick_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one transfer; ack must follow exactly one cycle later and drop the cycle after.
    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       output logic [31:0] rd);
        iomem_valid = 1'b1;
        iomem_addr  = a;
        iomem_wdata = wd;
        iomem_wstrb = ws;
        step();
        check("ack", {31'b0, iomem_ready}, 32'd1);
        rd = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0000;
        step();
        check("ack_pulse", {31'b0, iomem_ready}, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(a, wd, 4'hF, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] expv);
        logic [31:0] v;
        bus(a, 32'h0, 4'h0, v);
        check(tag, v, expv);
    endtask

    task automatic wait_tick(input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < bound);
    endtask

    initial begin
        int n;
        int t0;
        logic [31:0] v;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_tick", {31'b0, tick}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_ready", {31'b0, iomem_ready}, 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);

        for (int i = 0; i < 7; i++) begin
            rd_check("rst_reg", BASE + 32'(i * 4), 32'd0);
        end

        bus(A_RELOAD, 32'hAABB_CCDD, 4'b0101, v);
        rd_check("strobe_reload", A_RELOAD, 32'h00BB_00DD);
        wr(BASE + 32'h20, 32'hFFFF_FFFF);
        rd_check("hole_read", BASE + 32'h20, 32'd0);

        iomem_valid = 1'b1;
        iomem_addr  = BASE + 32'h100;
        iomem_wstrb = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            check("outside_noack", {31'b0, iomem_ready}, 32'd0);
        end
        iomem_valid = 1'b0;
        step();

        // Auto-reload: period (2+1)*(3+1) = 12.
        wr(A_PRESCALE, 32'd2);
        wr(A_RELOAD, 32'd3);
        wr(A_COUNT, 32'd3);
        wr(A_CTRL, 32'h3);
        wait_tick(40, n);
        check("ar_first_tick", 32'(n), 32'd11);
        wait_tick(40, n);
        check("ar_period", 32'(n), 32'd12);
        rd_check("ar_exp_set", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd1);
        rd_check("ar_exp_clr", A_STATUS, 32'd0);
        wr(A_CTRL, 32'h7);
        check("irq_low", {31'b0, irq}, 32'd0);
        wait_tick(40, n);
        check("ar_no_pc_clear", 32'(n), 32'd4);
        check("irq_high", {31'b0, irq}, 32'd1);
        wr(A_STATUS, 32'd1);
        check("irq_cleared", {31'b0, irq}, 32'd0);
        wr(A_CTRL, 32'h0);

        // One-shot.
        wr(A_PRESCALE, 32'd0);
        wr(A_COUNT, 32'd5);
        t0 = tick_cnt;
        wr(A_CTRL, 32'h1);
        wait_tick(40, n);
        check("os_tick_time", 32'(n), 32'd5);
        rd_check("os_ctrl", A_CTRL, 32'd0);
        rd_check("os_count", A_COUNT, 32'd0);
        repeat (20) step();
        check("os_single_tick", 32'(tick_cnt - t0), 32'd1);
        rd_check("os_count_hold", A_COUNT, 32'd0);
        rd_check("os_exp", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd1);

        // COUNT write lands on the expiry edge.
        wr(A_PRESCALE, 32'd3);
        wr(A_RELOAD, 32'd5);
        wr(A_COUNT, 32'd0);
        t0 = tick_cnt;
        wr(A_CTRL, 32'h3);
        step();
        step();
        wr(A_COUNT, 32'd7);
        rd_check("col_count", A_COUNT, 32'd7);
        rd_check("col_no_exp", A_STATUS, 32'd0);
        check("col_no_tick", 32'(tick_cnt - t0), 32'd0);
        wr(A_CTRL, 32'h0);

        // W1C lands on the EXP-set edge.
        wr(A_COUNT, 32'd0);
        t0 = tick_cnt;
        wr(A_CTRL, 32'h3);
        step();
        step();
        wr(A_STATUS, 32'd1);
        rd_check("w1c_set_wins", A_STATUS, 32'd1);
        check("w1c_tick", 32'(tick_cnt - t0), 32'd1);
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'd1);
        rd_check("w1c_after", A_STATUS, 32'd0);

`ifdef IOMEM_TIMER_CAPTURE_EN
        wr(A_PRESCALE, 32'd0);
        wr(A_COUNT, 32'd100);
        wr(A_CTRL, 32'h1);
        repeat (9) step();
        capture_in = 1'b1;
        step();
        capture_in = 1'b0;
        rd_check("cap_value", A_CAPTURE, 32'd90);
        rd_check("cap_status", A_STATUS, 32'd2);
        wr(A_CTRL, 32'h0);
`else
        rd_check("no_capture_reg", A_CAPTURE, 32'd0);
`endif

        // Reset during the hit cycle drops the ack.
        iomem_valid = 1'b1;
        iomem_addr  = A_COUNT;
        iomem_wstrb = 4'b0000;
        reset       = 1'b1;
        step();
        check("rst_mid_ready", {31'b0, iomem_ready}, 32'd0);
        check("rst_mid_rdata", iomem_rdata, 32'd0);
        reset       = 1'b0;
        iomem_valid = 1'b0;
        step();
        rd_check("rst_mid_count", A_COUNT, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
